lorenz_euler_step: RTL and testbench

- Fixed-point Lorenz integrator that generates the raw x/y/z trajectory.
- Sits directly upstream of the 3-axis scale stage and feeds it through a valid/ready handshake.
- Each step is one explicit-Euler update: dx=σ(y−x), dy=x(ρ−z)−y, dz=xy−βz, then s'=s+dt·ds.
- One shared multiplier handles the step, issuing one product per cycle over 7 cycles.

---
 rtl/lorenz_pkg.sv | 36 +++
 rtl/lorenz_euler_step_mul.sv | 26 ++
 rtl/lorenz_euler_step.sv | 129 ++++++++++++
 tb/tb_lorenz_euler_step.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lorenz_pkg.sv
// Shared fixed-point format, FSM state type and saturating arithmetic for the Lorenz integrator.
package lorenz_pkg;

    localparam int unsigned IntegerBits  = 6;
    localparam int unsigned FractionBits = 25;
    localparam int unsigned TotalBits    = 1 + IntegerBits + FractionBits;

    localparam logic signed [TotalBits-1:0] One    = {{(TotalBits-1){1'b0}}, 1'b1} << FractionBits;
    localparam logic signed [TotalBits-1:0] MaxVal = {1'b0, {(TotalBits-1){1'b1}}};
    localparam logic signed [TotalBits-1:0] MinVal = {1'b1, {(TotalBits-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    // One guard bit is enough to detect overflow of a single add or subtract.
    function automatic logic signed [TotalBits-1:0] sat_addsub(
        input logic signed [TotalBits-1:0] a,
        input logic signed [TotalBits-1:0] b,
        input logic                        sub
    );
        logic [TotalBits:0] s;
        if (sub) begin
            s = {a[TotalBits-1], a} - {b[TotalBits-1], b};
        end else begin
            s = {a[TotalBits-1], a} + {b[TotalBits-1], b};
        end
        if (s[TotalBits] != s[TotalBits-1]) begin
            return s[TotalBits] ? MinVal : MaxVal;
        end
        return s[TotalBits-1:0];
    endfunction

endpackage

// File: rtl/lorenz_euler_step_mul.sv
// Combinational Q-format multiply: full-width product, floor shift by the fraction, saturate.
module fixed_mul_sat
    import lorenz_pkg::*;
(
    input  logic signed [TotalBits-1:0] a,
    input  logic signed [TotalBits-1:0] b,
    output logic signed [TotalBits-1:0] p
);

    logic signed [2*TotalBits-1:0] full;
    logic signed [2*TotalBits-1:0] shifted;
    logic        [TotalBits:0]     hi;

    always_comb begin
        full    = a * b;
        shifted = full >>> FractionBits;
        // The result fits only if every bit above the kept sign bit matches it.
        hi      = shifted[2*TotalBits-1:TotalBits-1];
        if ((&hi) || (~|hi)) begin
            p = shifted[TotalBits-1:0];
        end else begin
            p = shifted[2*TotalBits-1] ? MinVal : MaxVal;
        end
    end

endmodule

// File: rtl/lorenz_euler_step.sv
// Explicit-Euler Lorenz step engine: seven shared-multiplier cycles per step, valid/ready output.
module lorenz_euler_step
    import lorenz_pkg::*;
#(
    parameter logic signed [TotalBits-1:0] X0 = One,
    parameter logic signed [TotalBits-1:0] Y0 = One,
    parameter logic signed [TotalBits-1:0] Z0 = One
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        run,
    input  logic signed [TotalBits-1:0] sigma,
    input  logic signed [TotalBits-1:0] rho,
    input  logic signed [TotalBits-1:0] beta,
    input  logic signed [TotalBits-1:0] dt,
    output logic signed [TotalBits-1:0] xOut,
    output logic signed [TotalBits-1:0] yOut,
    output logic signed [TotalBits-1:0] zOut,
    output logic                        outValid,
    input  logic                        outReady,
    output logic                        busy
);

    state_e state_q, state_d;
    logic   start;
    logic [2:0] cnt_q;

    logic signed [TotalBits-1:0] sigma_q, rho_q, beta_q, dt_q;
    logic signed [TotalBits-1:0] x_q, y_q, z_q;
    logic signed [TotalBits-1:0] dx_q, dy_q, dz_q, p2_q, xn_q, yn_q;
    logic signed [TotalBits-1:0] mul_a, mul_b, mul_p;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StCalc;
                    start   = 1'b1;
                end
            end
            StCalc: begin
                if (cnt_q == 3'd6) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (outReady) begin
                    state_d = run ? StCalc : StIdle;
                    start   = run;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        outValid = (state_q == StDone);
        busy     = (state_q == StCalc);
    end

    // Operand selection for the single multiplier, one product per CALC cycle.
    always_comb begin
        mul_a = dt_q;
        mul_b = dz_q;
        case (cnt_q)
            3'd0: begin mul_a = sigma_q; mul_b = sat_addsub(y_q, x_q, 1'b1);   end
            3'd1: begin mul_a = x_q;     mul_b = sat_addsub(rho_q, z_q, 1'b1); end
            3'd2: begin mul_a = x_q;     mul_b = y_q;                          end
            3'd3: begin mul_a = beta_q;  mul_b = z_q;                          end
            3'd4: begin mul_a = dt_q;    mul_b = dx_q;                         end
            3'd5: begin mul_a = dt_q;    mul_b = dy_q;                         end
            default: begin mul_a = dt_q; mul_b = dz_q;                         end
        endcase
    end

    fixed_mul_sat u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            x_q   <= X0;
            y_q   <= Y0;
            z_q   <= Z0;
            xOut  <= '0;
            yOut  <= '0;
            zOut  <= '0;
            cnt_q <= '0;
        end else if (start) begin
            sigma_q <= sigma;
            rho_q   <= rho;
            beta_q  <= beta;
            dt_q    <= dt;
            cnt_q   <= '0;
        end else if (state_q == StCalc) begin
            cnt_q <= cnt_q + 3'd1;
            case (cnt_q)
                3'd0: dx_q <= mul_p;
                3'd1: dy_q <= sat_addsub(mul_p, y_q, 1'b1);
                3'd2: p2_q <= mul_p;
                3'd3: dz_q <= sat_addsub(p2_q, mul_p, 1'b1);
                3'd4: xn_q <= sat_addsub(x_q, mul_p, 1'b0);
                3'd5: yn_q <= sat_addsub(y_q, mul_p, 1'b0);
                3'd6: begin
                    x_q  <= xn_q;
                    y_q  <= yn_q;
                    z_q  <= sat_addsub(z_q, mul_p, 1'b0);
                    xOut <= xn_q;
                    yOut <= yn_q;
                    zOut <= sat_addsub(z_q, mul_p, 1'b0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lorenz_euler_step.sv
// Directed bench for lorenz_euler_step with a cycle-level behavioural model checked every cycle.
module tb_lorenz_euler_step;

    localparam longint QMax = 64'sd2147483647;
    localparam longint QMin = -64'sd2147483648;
    localparam longint QOne = 64'sd33554432;

    logic clk = 1'b0;
    logic resetN, run, outReady;
    logic signed [31:0] sigma, rho, beta, dt;
    logic signed [31:0] xOut, yOut, zOut;
    logic outValid, busy;

    logic run_s;
    logic signed [31:0] xs, ys, zs;
    logic vs, bs;

    int n_checks = 0;
    int n_fail = 0;
    bit model_on = 1'b0;

    always #5 clk = ~clk;

    lorenz_euler_step dut (
        .clk(clk), .resetN(resetN), .run(run),
        .sigma(sigma), .rho(rho), .beta(beta), .dt(dt),
        .xOut(xOut), .yOut(yOut), .zOut(zOut),
        .outValid(outValid), .outReady(outReady), .busy(busy)
    );

    lorenz_euler_step #(
        .X0(32'sh7FFFFFFF), .Y0(32'sh7FFFFFFF), .Z0(32'sh7FFFFFFF)
    ) dut_sat (
        .clk(clk), .resetN(resetN), .run(run_s),
        .sigma(32'sh7FFFFFFF), .rho(32'sd0), .beta(32'sd0), .dt(32'sd33554432),
        .xOut(xs), .yOut(ys), .zOut(zs),
        .outValid(vs), .outReady(1'b0), .busy(bs)
    );

    // ---------------- behavioural model ----------------
    function automatic longint sat(longint v);
        if (v > QMax) return QMax;
        if (v < QMin) return QMin;
        return v;
    endfunction

    function automatic longint qmul(longint a, longint b);
        return sat((a * b) >>> 25);
    endfunction

    task automatic model_step(inout longint x, inout longint y, inout longint z,
                              input longint s, input longint r, input longint b,
                              input longint d);
        longint dx, dy, dz;
        dx = qmul(s, sat(y - x));
        dy = sat(qmul(x, sat(r - z)) - y);
        dz = sat(qmul(x, y) - qmul(b, z));
        x  = sat(x + qmul(d, dx));
        y  = sat(y + qmul(d, dy));
        z  = sat(z + qmul(d, dz));
    endtask

    // Model phase: 0 idle, 1 computing, 2 holding a result.
    int     m_phase, m_left;
    longint m_x, m_y, m_z, m_ox, m_oy, m_oz;
    longint c_s, c_r, c_b, c_d;

    always @(posedge clk) begin
        if (!resetN) begin
            m_phase = 0;
            m_x = QOne; m_y = QOne; m_z = QOne;
            m_ox = 0; m_oy = 0; m_oz = 0;
        end else begin
            case (m_phase)
                0: if (run) begin
                    c_s = sigma; c_r = rho; c_b = beta; c_d = dt;
                    m_phase = 1; m_left = 7;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        model_step(m_x, m_y, m_z, c_s, c_r, c_b, c_d);
                        m_ox = m_x; m_oy = m_y; m_oz = m_z;
                        m_phase = 2;
                    end
                end
                default: if (outReady) begin
                    if (run) begin
                        c_s = sigma; c_r = rho; c_b = beta; c_d = dt;
                        m_phase = 1; m_left = 7;
                    end else begin
                        m_phase = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            n_checks++;
            if (outValid !== (m_phase == 2) || busy !== (m_phase == 1) ||
                xOut !== 32'(m_ox) || yOut !== 32'(m_oy) || zOut !== 32'(m_oz)) begin
                n_fail++;
                $display("FAIL model t=%0t: got v=%b b=%b x=%0d y=%0d z=%0d, want v=%b b=%b x=%0d y=%0d z=%0d",
                         $time, outValid, busy, xOut, yOut, zOut,
                         m_phase == 2, m_phase == 1, m_ox, m_oy, m_oz);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_first(input string tag);
        check({tag, " valid"}, outValid, 1);
        check({tag, " x"}, xOut, 33554432);
        check({tag, " y"}, yOut, 40370176);
        check({tag, " z"}, zOut, 33117525);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        longint px, py, pz;
        int accepts, last;

        // Pin the model against hand-derived results.
        px = QOne; py = QOne; pz = QOne;
        model_step(px, py, pz, 335544320, 939524096, 89478485, 262144);
        check("model first x", px, 33554432);
        check("model first y", py, 40370176);
        check("model first z", pz, 33117525);
        px = QMax; py = QMax; pz = QMax;
        model_step(px, py, pz, QMax, 0, 0, QOne);
        check("model sat x", px, QMax);
        check("model sat y", py, -1);
        check("model sat z", pz, QMax);

        resetN = 1'b0; run = 1'b0; run_s = 1'b0; outReady = 1'b0;
        sigma = 32'sd335544320; rho = 32'sd939524096;
        beta = 32'sd89478485;   dt = 32'sd262144;
        cyc(2);
        model_on = 1'b1;
        check("reset valid", outValid, 0);
        check("reset busy", busy, 0);
        check("reset x", xOut, 0);
        resetN = 1'b1;
        cyc(1);

        // First step plus a matching saturating step on the second instance.
        run = 1'b1; run_s = 1'b1;
        cyc(1);
        run = 1'b0; run_s = 1'b0;
        check("busy in calc", busy, 1);
        cyc(6);
        check("not yet valid", outValid, 0);
        cyc(1);
        check_first("first");
        check("sat valid", vs, 1);
        check("sat x", xs, QMax);
        check("sat y", ys, -1);
        check("sat z", zs, QMax);

        // Backpressure hold.
        cyc(20);
        check_first("hold");
        check("hold busy", busy, 0);

        // Accept, then continuous streaming.
        outReady = 1'b1; run = 1'b1;
        cyc(1);
        check("drop after accept", outValid, 0);
        accepts = 0; last = -1;
        for (int i = 0; i < 80; i++) begin
            if (outValid && outReady) begin
                accepts++;
                if (last >= 0) check("period", i - last, 8);
                last = i;
            end
            cyc(1);
        end
        check("accepts in 80", accepts, 10);
        run = 1'b0;
        cyc(10);
        outReady = 1'b0;
        check("idle after drain", busy, 0);

        // Reset in the middle of a step.
        resetN = 1'b0; cyc(1); resetN = 1'b1;
        run = 1'b1; cyc(1); run = 1'b0;
        cyc(3);
        resetN = 1'b0; cyc(1);
        check("midreset valid", outValid, 0);
        check("midreset busy", busy, 0);
        check("midreset x", xOut, 0);
        resetN = 1'b1;
        run = 1'b1; cyc(1); run = 1'b0;
        cyc(7);
        check_first("rerun");
        outReady = 1'b1; cyc(1); outReady = 1'b0;

        // Coefficients are captured at step start.
        resetN = 1'b0; cyc(1); resetN = 1'b1;
        run = 1'b1; cyc(1); run = 1'b0;
        cyc(2);
        sigma = 32'sd0;
        cyc(5);
        check_first("sigma change");
        sigma = 32'sd335544320;
        outReady = 1'b1; cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
